// File: rtl/div_seq.sv
// div_seq: sequential radix-2 restoring divider.
// One quotient bit per clock, signed or unsigned operands, divide-by-zero and
// signed-overflow flags, valid/ready handshake on the operand and result sides.
module div_seq #(
    parameter int DW = 26,  // dividend / quotient width
    parameter int VW = 11   // divisor / remainder width, 2 <= VW <= DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sgn,
    input  logic [DW-1:0] in_did,
    input  logic [VW-1:0] in_div,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quo,
    output logic [VW-1:0] rem,
    output logic          err,
    output logic          ovf
);

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t        state_q;
    logic [DW-1:0] dq_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [VW-1:0] dv_q;      // divisor magnitude
    logic [VW-1:0] pr_q;      // partial remainder, always < divisor so VW bits hold it
    logic [CW-1:0] cnt_q;     // iterations completed
    logic          neg_q_q;   // quotient must be negated
    logic          neg_r_q;   // remainder must be negated (follows dividend sign)
    logic          ovf_pend_q;
    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic          err_q;
    logic          ovf_q;

    // Operand magnitudes at accept; |-2^(N-1)| still fits N unsigned bits.
    logic [DW-1:0] did_mag;
    logic [VW-1:0] div_mag;
    logic          is_ovf;

    // Single restoring iteration on the current datapath registers.
    logic [VW:0]   pr_sh;
    logic          take;
    logic [VW-1:0] pr_d;
    logic [DW-1:0] dq_d;

    // Accept-time operand conditioning.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        did_mag = in_did;
        div_mag = in_div;
        if (in_sgn && in_did[DW-1]) did_mag = -in_did;
        if (in_sgn && in_div[VW-1]) div_mag = -in_div;
        is_ovf  = in_sgn && (in_did == {1'b1, {(DW-1){1'b0}}}) && (in_div == '1);
    end

    // Compare-and-subtract step; the VW+1-bit shifted remainder keeps the compare exact.
    always_comb begin
        pr_sh = {pr_q, dq_q[DW-1]};
        take  = (pr_sh >= {1'b0, dv_q});
        pr_d  = pr_sh[VW-1:0];
        if (take) pr_d = pr_sh[VW-1:0] - dv_q;  // true difference is < divisor, low bits are exact
        dq_d  = {dq_q[DW-2:0], take};
    end

    // Control FSM plus datapath and registered result outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            dq_q       <= '0;
            dv_q       <= '0;
            pr_q       <= '0;
            cnt_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (in_div == '0) begin
                            quo_q   <= '1;
                            rem_q   <= '0;
                            err_q   <= 1'b1;
                            ovf_q   <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            dq_q       <= did_mag;
                            dv_q       <= div_mag;
                            pr_q       <= '0;
                            cnt_q      <= '0;
                            neg_q_q    <= in_sgn & (in_did[DW-1] ^ in_div[VW-1]);
                            neg_r_q    <= in_sgn & in_did[DW-1];
                            ovf_pend_q <= is_ovf;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    dq_q  <= dq_d;
                    pr_q  <= pr_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DW - 1)) state_q <= FIX;
                end
                FIX: begin
                    quo_q   <= neg_q_q ? -dq_q : dq_q;
                    rem_q   <= neg_r_q ? -pr_q : pr_q;
                    err_q   <= 1'b0;
                    ovf_q   <= ovf_pend_q;
                    state_q <= DONE;
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quo       = quo_q;
    assign rem       = rem_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule
